// File: rtl/ifetch_if.sv
// Fetch-stage port bundle: ROM address/data, redirect, and the decode handshake.
// The stall_cnt signal exists only when IFETCH_STALL_CNT_EN is defined.
interface ifetch_if;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // Decode handshake: an entry transfers on a rising edge where out_valid && out_ready.
  // out_valid, out_pc and out_instr never depend on out_ready and hold while stalled.
  // A redirect in the same cycle cancels the transfer.
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  modport master (
    input  fetch_en, rom_data, redirect_valid, redirect_pc, out_ready,
    output rom_addr, out_valid, out_instr, out_pc,
`ifdef IFETCH_STALL_CNT_EN
    output stall_cnt,
`endif
    output misalign_err
  );

  modport slave (
    output fetch_en, rom_data, redirect_valid, redirect_pc, out_ready,
    input  rom_addr, out_valid, out_instr, out_pc,
`ifdef IFETCH_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  misalign_err
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, same-cycle ROM capture, DEPTH-entry prefetch FIFO, redirect flush.
// Optional stall counter output enabled by defining IFETCH_STALL_CNT_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic      clk,
  input logic      rst_n,
  ifetch_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  typedef logic [AW-1:0] ptr_t;

  logic [31:0] pc_q;
  ptr_t        rd_ptr, wr_ptr, rd_next;
  logic [AW:0] count, count_next;
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] head_pc_q, head_instr_q;
  logic        misalign_q;
  logic        pop, push;

  always_comb begin
    pop        = 1'b0;
    push       = 1'b0;
    rd_next    = rd_ptr;
    count_next = count;
    pop  = (count != '0) && bus.out_ready;
    push = bus.fetch_en && !bus.redirect_valid && ((count < DEPTH_C) || pop);
    if (pop) rd_next = rd_ptr + ptr_t'(1);
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Head registers: the slot written this edge becomes the head only when nothing older remains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      misalign_q   <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q   <= {bus.redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (bus.redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
    end else begin
      if (push) begin
        pc_q   <= pc_q + 32'd4;
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) begin
        if (push && (wr_ptr == rd_next)) begin
          head_pc_q    <= pc_q;
          head_instr_q <= bus.rom_data;
        end else begin
          head_pc_q    <= pc_mem[rd_next];
          head_instr_q <= instr_mem[rd_next];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_q;
      instr_mem[wr_ptr] <= bus.rom_data;
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  // Counts cycles where fetch wanted to run but the buffer had no room; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (bus.fetch_en && !bus.redirect_valid && !push && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif

  assign bus.rom_addr     = pc_q;
  assign bus.out_valid    = (count != '0);
  assign bus.out_pc       = head_pc_q;
  assign bus.out_instr    = head_instr_q;
  assign bus.misalign_err = misalign_q;
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the combinational 4 KiB byte ROM.
- Owns the PC, drives the ROM word address, and captures the little-endian 32-bit word the ROM returns in the same cycle.
- Buffers fetched words with their PCs in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects that flush the buffer.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_en  input  1  when 0, no new fetches; PC holds; buffered entries still drain.
- rom_addr  output  32  byte address to ROM; always equals the current PC (combinational from the PC register).
- rom_data  input  32  instruction word from ROM, valid in the same cycle as rom_addr.
- redirect_valid  input  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  input  32  redirect target.
- out_valid  output  1  head FIFO entry valid.
- out_ready  input  1  decode accepts the head entry.
- out_instr  output  32  instruction word of the head entry.
- out_pc  output  32  PC of the head entry.
- misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async assert, deasserted synchronously by the environment):
  - PC = RESET_PC; FIFO count = 0; read/write pointers = 0.
  - out_valid = 0, out_instr = 0, out_pc = 0, misalign_err = 0.
  - stall_cnt = 0 when the optional feature is present.
  - Reset mid-operation discards all buffered entries immediately.
- pop = out_valid && out_ready.
- push = fetch_en && !redirect_valid && (count < DEPTH || pop).
- On push, at the rising edge:
  - Entry {PC, rom_data} is written at the write pointer.
  - PC <= PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Latency: a word captured at edge N appears on out_instr/out_pc in the cycle after edge N (one cycle after its address was on rom_addr). No combinational path from rom_data to the outputs.
- out_valid = (count != 0). out_instr/out_pc come from registered FIFO storage at the read pointer and stay stable while out_valid && !out_ready.
- Full (count == DEPTH):
  - No push unless a pop occurs in the same cycle.
  - Simultaneous push and pop when full: count unchanged, both pointers advance.
- Empty: pop is impossible (out_valid = 0); out_instr/out_pc hold their last values.
- Redirect (highest priority, overrides push and pop):
  - count <= 0 and pointers reset; PC <= {redirect_pc[31:2], 2'b00}; no entry written that cycle.
  - The head presented in the redirect cycle is discarded even if out_ready = 1. Decode must not consume it.
  - out_valid is 0 in the next cycle. The first post-redirect word is valid one cycle after that.
  - If redirect_pc[1:0] != 0, misalign_err is set; it clears only on reset.
- fetch_en = 0:
  - No push; PC frozen; pops continue.
  - A redirect while fetch_en = 0 still flushes and loads the PC.
- Sequencing: ordering is strictly FIFO; out_pc of consecutive accepted entries increments by 4 unless a redirect intervenes.

Optional Feature:
- Macro IFETCH_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0], a counter that increments on every cycle where fetch_en = 1, redirect_valid = 0 and push = 0 (buffer full with no pop). It saturates at 32'hFFFF_FFFF, resets to 0, and is unaffected by redirects.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC = 0, ROM words 0x11111111, 0x22222222, 0x33333333 at 0x0/0x4/0x8, out_ready = 1 -> rom_addr sequence 0, 4, 8; out_valid rises 1 cycle after the first edge. Outputs (0, 0x11111111), (4, 0x22222222), (8, 0x33333333) on consecutive cycles.
- out_ready = 0 for 5 cycles from reset -> count reaches 2 and out_valid stays 1. out_pc holds at 0; PC stops at 8. stall_cnt = 3 with IFETCH_STALL_CNT_EN. Raising out_ready drains 0, 4, 8 in order.
- Redirect to 0x100 while out_pc = 0x4 is presented with out_ready = 1 -> entry 0x4 is not consumed and out_valid = 0 the next cycle. The next outputs are 0x100, then 0x104; misalign_err stays 0.
- Redirect to 0x202 -> misalign_err = 1 (sticky); fetch resumes at 0x200; a later aligned redirect leaves misalign_err = 1 until rst_n = 0.
- fetch_en = 0 with 1 entry buffered, out_ready = 1 -> that entry drains, then out_valid = 0 and rom_addr is frozen. fetch_en = 1 resumes from the frozen PC.
- RESET_PC = 32'hFFFF_FFF8 -> outputs 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000 (wrap). Asserting rst_n = 0 mid-stream clears out_valid immediately.
